// File: rtl/elevator_controller.sv
// rtl/elevator_controller.sv - 3-floor car scheduler and motion/door sequencer
// Optional intermediate-floor intercept: define ELEVATOR_INTERCEPT_EN.
module elevator_controller #(
    parameter logic [1:0] LABEL_F1      = 2'b00,
    parameter logic [1:0] LABEL_F2      = 2'b01,
    parameter logic [1:0] LABEL_F3      = 2'b10,
    parameter int         TRAVEL_CYCLES = 4,
    parameter int         DOOR_CYCLES   = 3,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic       moving,
    output logic [1:0] goal_floor,
    output logic [1:0] current_floor,
    output logic       door_open,
    output logic       dir_up
);

    localparam logic [CNT_W-1:0] TRAVEL_RELOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_RELOAD   = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       cur_idx, cur_idx_nxt;
    logic [1:0]       goal_idx, goal_idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             moving_nxt, door_nxt, dir_nxt;

    logic             here_req;
    logic             above_any, below_any;
    logic [1:0]       above_idx, below_idx;
    logic             intercept;
    logic [1:0]       eff_goal;
    logic [1:0]       step_idx;

    // Floors are tracked as indices 0..2 internally; labels exist only on the ports.
    function automatic logic [1:0] label_of(input logic [1:0] idx);
        case (idx)
            2'd1:    return LABEL_F2;
            2'd2:    return LABEL_F3;
            default: return LABEL_F1;
        endcase
    endfunction

    always_comb begin
        here_req  = 1'b0;
        above_any = 1'b0;
        below_any = 1'b0;
        above_idx = cur_idx;
        below_idx = cur_idx;
        case (cur_idx)
            2'd0: begin
                here_req  = req[0];
                above_any = req[1] | req[2];
                above_idx = req[1] ? 2'd1 : 2'd2;
            end
            2'd1: begin
                here_req  = req[1];
                above_any = req[2];
                above_idx = 2'd2;
                below_any = req[0];
                below_idx = 2'd0;
            end
            default: begin
                here_req  = req[2];
                below_any = req[1] | req[0];
                below_idx = req[1] ? 2'd1 : 2'd0;
            end
        endcase
    end

`ifdef ELEVATOR_INTERCEPT_EN
    // Only a real F1<->F3 trip passes F2; zero-travel pulses (goal == cur) are excluded.
    assign intercept = (state == MOVE) && req[1] && (cur_idx != 2'd1) &&
                       (goal_idx != 2'd1) && (goal_idx != cur_idx);
`else
    assign intercept = 1'b0;
`endif

    assign eff_goal = intercept ? 2'd1 : goal_idx;
    assign step_idx = (eff_goal > cur_idx) ? (cur_idx + 2'd1) : (cur_idx - 2'd1);

    always_comb begin
        state_nxt    = state;
        cur_idx_nxt  = cur_idx;
        goal_idx_nxt = goal_idx;
        cnt_nxt      = cnt;
        moving_nxt   = moving;
        door_nxt     = door_open;
        dir_nxt      = dir_up;

        case (state)
            IDLE: begin
                if (here_req) begin
                    // Zero-travel: one-cycle moving pulse acknowledges the current floor.
                    goal_idx_nxt = cur_idx;
                    moving_nxt   = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = MOVE;
                end else if (dir_up && above_any) begin
                    goal_idx_nxt = above_idx;
                    moving_nxt   = 1'b1;
                    cnt_nxt      = TRAVEL_RELOAD;
                    state_nxt    = MOVE;
                end else if (below_any) begin
                    goal_idx_nxt = below_idx;
                    dir_nxt      = 1'b0;
                    moving_nxt   = 1'b1;
                    cnt_nxt      = TRAVEL_RELOAD;
                    state_nxt    = MOVE;
                end else if (above_any) begin
                    goal_idx_nxt = above_idx;
                    dir_nxt      = 1'b1;
                    moving_nxt   = 1'b1;
                    cnt_nxt      = TRAVEL_RELOAD;
                    state_nxt    = MOVE;
                end
            end

            MOVE: begin
                goal_idx_nxt = eff_goal;
                if (cur_idx == eff_goal) begin
                    moving_nxt = 1'b0;
                    door_nxt   = 1'b1;
                    cnt_nxt    = DOOR_RELOAD;
                    state_nxt  = DOOR;
                end else if (cnt == '0) begin
                    cur_idx_nxt = step_idx;
                    if (step_idx == eff_goal) begin
                        moving_nxt = 1'b0;
                        door_nxt   = 1'b1;
                        cnt_nxt    = DOOR_RELOAD;
                        state_nxt  = DOOR;
                    end else begin
                        cnt_nxt = TRAVEL_RELOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            DOOR: begin
                if (cnt == '0) begin
                    door_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_idx       <= 2'd0;
            goal_idx      <= 2'd0;
            cnt           <= '0;
            moving        <= 1'b0;
            door_open     <= 1'b0;
            dir_up        <= 1'b1;
            current_floor <= LABEL_F1;
            goal_floor    <= LABEL_F1;
        end else begin
            state         <= state_nxt;
            cur_idx       <= cur_idx_nxt;
            goal_idx      <= goal_idx_nxt;
            cnt           <= cnt_nxt;
            moving        <= moving_nxt;
            door_open     <= door_nxt;
            dir_up        <= dir_nxt;
            current_floor <= label_of(cur_idx_nxt);
            goal_floor    <= label_of(goal_idx_nxt);
        end
    end

endmodule

// File: tb/tb_elevator_controller.sv
// tb/tb_elevator_controller.sv - directed self-checking bench for elevator_controller
module tb_elevator_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic       moving;
    logic [1:0] goal_floor;
    logic [1:0] current_floor;
    logic       door_open;
    logic       dir_up;

    int checks = 0;
    int failures = 0;

    elevator_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .moving       (moving),
        .goal_floor   (goal_floor),
        .current_floor(current_floor),
        .door_open    (door_open),
        .dir_up       (dir_up)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full service: launch, moving duration, arrival, door duration.
    task automatic trip(input string tag, input logic [2:0] r, input logic [2:0] r_after,
                        input logic [2:0] door_r, input logic [1:0] g, input int cycles,
                        input logic d);
        int n;
        int dn;
        req = r;
        step();
        chk({tag, "_moving_rise"}, moving, 1);
        chk({tag, "_goal"}, goal_floor, g);
        chk({tag, "_dir"}, dir_up, d);
        req = r_after;
        n = 1;
        while (moving === 1'b1 && n < 40) begin
            step();
            if (moving === 1'b1) begin
                n++;
                chk({tag, "_goal_frozen"}, goal_floor, g);
                if (cycles == 8 && n == 5) chk({tag, "_mid_floor"}, current_floor, 2'b01);
            end
        end
        chk({tag, "_moving_cycles"}, n, cycles);
        chk({tag, "_door_rise"}, door_open, 1);
        chk({tag, "_arrive_floor"}, current_floor, g);
        dn = 1;
        while (door_open === 1'b1 && dn < 40) begin
            if (dn == 2) req = door_r;
            step();
            if (door_open === 1'b1) dn++;
        end
        chk({tag, "_door_cycles"}, dn, 3);
        chk({tag, "_idle_moving"}, moving, 0);
        chk({tag, "_idle_floor"}, current_floor, g);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        step();
        step();
        chk("rst_moving", moving, 0);
        chk("rst_door", door_open, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_cur", current_floor, 2'b00);
        chk("rst_goal", goal_floor, 2'b00);
        rst_n = 1'b1;
        step();
        chk("idle_hold", moving, 0);

        // F1->F3, with a call for F3 latched during the door phase
        trip("two_floor", 3'b100, 3'b000, 3'b100, 2'b10, 8, 1'b1);
        trip("door_req", 3'b100, 3'b000, 3'b000, 2'b10, 1, 1'b1);
        trip("f3_to_f2", 3'b010, 3'b000, 3'b000, 2'b01, 4, 1'b0);
        trip("zero_travel", 3'b010, 3'b000, 3'b000, 2'b01, 1, 1'b0);
        trip("f2_to_f1", 3'b001, 3'b000, 3'b000, 2'b00, 4, 1'b0);
        trip("f1_to_f2", 3'b010, 3'b000, 3'b000, 2'b01, 4, 1'b1);
        trip("prio_up", 3'b101, 3'b001, 3'b001, 2'b10, 4, 1'b1);
        trip("prio_down", 3'b001, 3'b000, 3'b000, 2'b00, 8, 1'b0);

        // Reset in the middle of a move, car between F2 and F3
        req = 3'b100;
        step();
        req = 3'b000;
        repeat (5) step();
        chk("pre_rst_moving", moving, 1);
        chk("pre_rst_cur", current_floor, 2'b01);
        rst_n = 1'b0;
        step();
        step();
        chk("mid_rst_moving", moving, 0);
        chk("mid_rst_door", door_open, 0);
        chk("mid_rst_dir", dir_up, 1);
        chk("mid_rst_cur", current_floor, 2'b00);
        chk("mid_rst_goal", goal_floor, 2'b00);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", moving, 0);

        // F1->F3 with an F2 call raised during the first travel step
        req = 3'b100;
        step();
        chk("icpt_launch_goal", goal_floor, 2'b10);
        step();
        req = 3'b110;
        step();
`ifdef ELEVATOR_INTERCEPT_EN
        chk("icpt_goal", goal_floor, 2'b01);
        step();
        chk("icpt_still_moving", moving, 1);
        step();
        chk("icpt_stop_moving", moving, 0);
        chk("icpt_stop_door", door_open, 1);
        chk("icpt_stop_floor", current_floor, 2'b01);
        req = 3'b100;
`else
        chk("noicpt_goal", goal_floor, 2'b10);
        repeat (5) step();
        chk("noicpt_moving_e7", moving, 1);
        chk("noicpt_goal_e7", goal_floor, 2'b10);
        step();
        chk("noicpt_stop_moving", moving, 0);
        chk("noicpt_stop_floor", current_floor, 2'b10);
        chk("noicpt_stop_door", door_open, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Car-side scheduler and motion sequencer for the 3-floor elevator.
- Consumes the latched hall-call lamps (pending requests) and chooses the next target floor.
- Times travel and door dwell.
- Drives `moving` and `goal_floor` back to the button block: a falling edge of `moving` while `goal_floor` is stable is what clears the served call lamp.

Parameters:
- LABEL_F1, 2'b00, floor-1 code on goal_floor/current_floor (floor index 0)
- LABEL_F2, 2'b01, floor-2 code (index 1)
- LABEL_F3, 2'b10, floor-3 code (index 2)
- TRAVEL_CYCLES, 4, clock cycles per one-floor step; legal range 1..2^CNT_W-1
- DOOR_CYCLES, 3, clock cycles door_open is held; legal range 1..2^CNT_W-1
- CNT_W, 8, width of the shared travel/door down-counter

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- req  input  3  pending calls, bit i = floor index i (the three button-block lamps); level-sensitive
- moving  output  1  car in motion; its falling edge acknowledges the served floor
- goal_floor  output  2  label of current target floor
- current_floor  output  2  label of floor the car is at or last passed
- door_open  output  1  doors open at current_floor
- dir_up  output  1  travel preference; 1 = up

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, via rst_n.
- Reset values, applied on the first clk edge with rst_n=0, regardless of state:
  - moving=0, door_open=0, dir_up=1
  - current_floor=LABEL_F1, goal_floor=LABEL_F1
  - counter=0, state=IDLE
- Reset mid-move does not preserve position; the car is defined to be at F1.
- All outputs are registered.
- FSM states: IDLE, MOVE, DOOR.
- IDLE, evaluated every cycle on req:
  - req[cur]=1: goal=cur, moving=1 for exactly one cycle (zero-travel ack pulse), then DOOR. door_open rises the cycle moving falls.
  - else if dir_up=1 and any req above cur: goal = nearest above.
  - else if any req below: goal = nearest below, dir_up=0.
  - else if any req above: goal = nearest above, dir_up=1.
  - For a nonzero goal: next cycle moving=1, goal_floor=goal, counter=TRAVEL_CYCLES-1, state MOVE.
  - req=0: stay IDLE; all outputs hold.
- MOVE:
  - counter decrements each cycle.
  - When counter=0 and cur≠goal: step current_floor one floor toward goal and reload counter=TRAVEL_CYCLES-1.
  - When the step lands on goal, in that same edge: moving←0, door_open←1, counter←DOOR_CYCLES-1, state DOOR.
  - Total moving-high time = floors×TRAVEL_CYCLES cycles.
  - goal_floor is frozen from MOVE entry until leaving DOOR, so the acknowledging edge always carries the correct label.
- DOOR:
  - door_open stays high DOOR_CYCLES cycles, then door_open←0, state IDLE.
  - Requests arriving during DOOR are ignored until IDLE, including a re-press of the current floor; that re-press gets served by a fresh zero-travel pulse.
- Direction: dir_up updates only in IDLE on goal selection. At F3 no "above" exists; at F1 no "below" exists.
- Simultaneous: req bits changing in the same cycle as a MOVE→DOOR transition have no effect on that transition.
- Invalid label 2'b11 never appears on goal_floor or current_floor.

Optional Feature:
- Macro: ELEVATOR_INTERCEPT_EN.
- Defined:
  - During MOVE, if the car is between floors heading toward goal and req becomes 1 for the intermediate floor F2 before the car reaches it, goal_floor is retargeted to LABEL_F2 in the next cycle.
  - The car stops there and follows the normal arrival/door sequence.
  - The original call remains pending and is rescheduled from IDLE.
  - Retarget is allowed only while current_floor ≠ LABEL_F2.
- Not defined: goal is fixed for the whole MOVE; no intermediate stops.

Test Plan:
- Reset: hold rst_n=0 two cycles mid-MOVE at current_floor=LABEL_F2 -> next edge moving=0, door_open=0, dir_up=1, current_floor=goal_floor=LABEL_F1, state IDLE.
- Two-floor trip: at F1 IDLE, req=3'b100 -> goal_floor=2'b10; moving high exactly 8 cycles; current_floor=01 after 4, 10 after 8; moving falls as door_open rises; door_open high 3 cycles; back to IDLE.
- Zero-travel: at F2 IDLE, req=3'b010 -> moving high exactly 1 cycle with goal_floor=01, then door_open high 3 cycles, current_floor unchanged.
- Direction priority: at F2, dir_up=1, req=3'b101 -> serves F3 first (goal 10, 4 cycles travel); with req still 3'b001 afterwards, goes to F1 (goal 00, dir_up=0, 8 cycles).
- Door-time request: during DOOR at F3, pulse req=3'b100 -> no effect until IDLE; then a 1-cycle moving pulse with goal_floor=10.
- Intercept (macro defined): F1→F3 trip, assert req[1] at cycle 2 of MOVE -> goal_floor=01 next cycle, stop at F2 after 4 cycles; without the macro the car goes straight to F3 in 8 cycles.
